// File: rtl/controls_debounce_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg -- shared definitions for the controls_debounce button front end.
//   btn_state_t     : per-channel FSM state encoding
//   cnt_width()     : counter width able to hold 0..max_count
//   DEF_*           : default timing constants (in clk cycles)
// ---------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESSED     = 2'd1,
      HELD_DELAY  = 2'd2,
      HELD_REPEAT = 2'd3
   } btn_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 10000;
   localparam int unsigned DEF_REPEAT_DELAY    = 5000000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 1000000;

   function automatic int unsigned cnt_width(input int unsigned max_count);
      return (max_count == 0) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/controls_debounce_if.sv
// ---------------------------------------------------------------------------
// controls_debounce_if -- button pins in, debounced level/pulses out.
//   btns        : raw asynchronous button pins
//   btn_level   : debounced pressed state (1 = pressed)
//   btn_press   : one-cycle pulse per accepted press (and per repeat)
//   btn_release : one-cycle pulse per accepted release
//   btn_any     : registered OR of btn_level
// master = pin/consumer side, slave = the debouncer.
// ---------------------------------------------------------------------------
interface controls_debounce_if #(
   parameter int unsigned N_CH = 2
);
   logic [N_CH-1:0] btns;
   logic [N_CH-1:0] btn_level;
   logic [N_CH-1:0] btn_press;
   logic [N_CH-1:0] btn_release;
   logic            btn_any;

   modport master (output btns, input btn_level, btn_press, btn_release, btn_any);
   modport slave  (input btns, output btn_level, btn_press, btn_release, btn_any);
endinterface

// File: rtl/controls_debounce_chan.sv
// ---------------------------------------------------------------------------
// debounce_chan -- one button channel: 2-flop synchroniser, polarity fix,
// stable-time debounce counter, press/release FSM and (when
// CTRL_AUTOREPEAT_EN is defined) auto-repeat of btn_press while held.
//   clk, rst    : clock, asynchronous active-low reset
//   pin         : raw asynchronous pin
//   btn_level   : debounced pressed state
//   btn_press   : one-cycle press / repeat pulse
//   btn_release : one-cycle release pulse
// ---------------------------------------------------------------------------
module debounce_chan
   import ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit          ACTIVE_LOW      = 1'b0,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_param
      $error("debounce_chan: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   localparam int unsigned    DW     = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0]  D_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          s;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          accept;
   btn_state_t    state_q, state_d;

   assign s      = sync_q[1] ^ ACTIVE_LOW;
   // Level change is accepted on the D-th consecutive differing sample.
   assign accept = (s != level_q) && (db_cnt_q == D_LAST);

`ifdef CTRL_AUTOREPEAT_EN
   localparam int unsigned    RW     = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                                : REPEAT_PERIOD);
   localparam logic [RW-1:0]  R_DLY  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]  R_PER  = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

   always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (accept)
         level_d = s;
      else if (s != level_q)
         db_cnt_d = db_cnt_q + DW'(1);
   end

   always_comb begin
      state_d   = state_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef CTRL_AUTOREPEAT_EN
      rpt_cnt_d = '0;
      case (state_q)
         RELEASED: begin
            if (accept && s) begin
               state_d = HELD_DELAY;
               press_d = 1'b1;
            end
         end
         HELD_DELAY, HELD_REPEAT: begin
            // A release wins over a coincident repeat so press/release never overlap.
            if (accept && !s) begin
               state_d   = RELEASED;
               release_d = 1'b1;
            end else if (rpt_cnt_q == ((state_q == HELD_DELAY) ? R_DLY : R_PER)) begin
               state_d = HELD_REPEAT;
               press_d = 1'b1;
            end else begin
               rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
         end
         default: state_d = RELEASED;
      endcase
`else
      case (state_q)
         RELEASED: begin
            if (accept && s) begin
               state_d = PRESSED;
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            if (accept && !s) begin
               state_d   = RELEASED;
               release_d = 1'b1;
            end
         end
         default: state_d = RELEASED;
      endcase
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q    <= '0;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         state_q   <= RELEASED;
`ifdef CTRL_AUTOREPEAT_EN
         rpt_cnt_q <= '0;
`endif
      end else begin
         sync_q    <= {sync_q[0], pin};
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         state_q   <= state_d;
`ifdef CTRL_AUTOREPEAT_EN
         rpt_cnt_q <= rpt_cnt_d;
`endif
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

// File: rtl/controls_debounce.sv
// ---------------------------------------------------------------------------
// controls_debounce -- N_CH-channel button front end. Each pin is
// synchronised, debounced and turned into a clean level plus one-cycle
// press/release pulses; btn_any is a registered OR of all levels.
// Optional auto-repeat of held buttons: define CTRL_AUTOREPEAT_EN.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : controls_debounce_if.slave (btns in; btn_level, btn_press,
//         btn_release, btn_any out)
// ---------------------------------------------------------------------------
module controls_debounce
   import ctrl_pkg::*;
#(
   parameter int unsigned N_CH            = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit          ACTIVE_LOW      = 1'b0,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                 clk,
   input  logic                 rst,
   controls_debounce_if.slave   bus
);

   logic [N_CH-1:0] level_w;
   logic [N_CH-1:0] press_w;
   logic [N_CH-1:0] release_w;
   logic            any_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .pin         (bus.btns[i]),
         .btn_level   (level_w[i]),
         .btn_press   (press_w[i]),
         .btn_release (release_w[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         any_q <= 1'b0;
      else
         any_q <= |level_w;
   end

   assign bus.btn_level   = level_w;
   assign bus.btn_press   = press_w;
   assign bus.btn_release = release_w;
   assign bus.btn_any     = any_q;

endmodule
